// File: rtl/load_store_unit.sv
// Load/store sequencer in front of a 64-bit doubleword-indexed data memory.
// Sub-doubleword stores run as read-modify-write; loads are lane-extracted and extended.
module load_store_unit #(
    parameter int DEPTH = 1024
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_store,
    input  logic [2:0]  req_funct3,
    input  logic [63:0] req_addr,
    input  logic [63:0] req_wdata,
    output logic        resp_valid,
    output logic [63:0] resp_rdata,
    output logic        resp_misalign,
    output logic        resp_fault,
    output logic [63:0] mem_addr,
    output logic [63:0] mem_wdata,
    output logic        mem_wr,
    input  logic [63:0] mem_rdata
);
    typedef enum logic [1:0] {IDLE, READ, WRITE, RESP} state_t;

    localparam logic [63:0] LIMIT = 64'(DEPTH) * 64'd8;

    state_t      state;
    logic [63:0] addr_q, wdata_q, wbuf_q, rdata_q;
    logic [2:0]  f3_q;
    logic        store_q, mis_q, fault_q;

    logic        req_fault, req_mis;
    logic [5:0]  sh;
    logic [63:0] lane, ld_ext, mask, mask_sh, merged;

    always_comb begin
        req_fault = (req_addr >= LIMIT) || (req_funct3 == 3'b111) || (req_store && req_funct3[2]);
        case (req_funct3[1:0])
            2'd1:    req_mis = req_addr[0];
            2'd2:    req_mis = |req_addr[1:0];
            2'd3:    req_mis = |req_addr[2:0];
            default: req_mis = 1'b0;
        endcase
    end

    // Lane extraction and merge work on the doubleword presented during READ.
    always_comb begin
        sh   = {addr_q[2:0], 3'b000};
        lane = mem_rdata >> sh;
        case (f3_q)
            3'b000:  ld_ext = {{56{lane[7]}},  lane[7:0]};
            3'b001:  ld_ext = {{48{lane[15]}}, lane[15:0]};
            3'b010:  ld_ext = {{32{lane[31]}}, lane[31:0]};
            3'b100:  ld_ext = {56'd0, lane[7:0]};
            3'b101:  ld_ext = {48'd0, lane[15:0]};
            3'b110:  ld_ext = {32'd0, lane[31:0]};
            default: ld_ext = lane;
        endcase
        case (f3_q[1:0])
            2'd0:    mask = 64'h0000_0000_0000_00FF;
            2'd1:    mask = 64'h0000_0000_0000_FFFF;
            2'd2:    mask = 64'h0000_0000_FFFF_FFFF;
            default: mask = '1;
        endcase
        mask_sh = mask << sh;
        merged  = (mem_rdata & ~mask_sh) | ((wdata_q << sh) & mask_sh);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            addr_q  <= '0;
            wdata_q <= '0;
            wbuf_q  <= '0;
            rdata_q <= '0;
            f3_q    <= '0;
            store_q <= 1'b0;
            mis_q   <= 1'b0;
            fault_q <= 1'b0;
        end else begin
            case (state)
                IDLE: if (req_valid) begin
                    addr_q  <= req_addr;
                    f3_q    <= req_funct3;
                    store_q <= req_store;
                    wdata_q <= req_wdata;
                    rdata_q <= '0;
                    mis_q   <= 1'b0;
                    fault_q <= 1'b0;
                    if (req_fault) begin
                        fault_q <= 1'b1;
                        state   <= RESP;
                    end else if (req_mis) begin
                        mis_q <= 1'b1;
                        state <= RESP;
                    end else if (req_store && req_funct3[1:0] == 2'd3) begin
                        wbuf_q <= req_wdata;
                        state  <= WRITE;
                    end else begin
                        state <= READ;
                    end
                end
                READ: begin
                    if (store_q) begin
                        wbuf_q <= merged;
                        state  <= WRITE;
                    end else begin
                        rdata_q <= ld_ext;
                        state   <= RESP;
                    end
                end
                WRITE:   state <= RESP;
                default: state <= IDLE;
            endcase
        end
    end

    assign req_ready     = (state == IDLE) && rst_n;
    assign resp_valid    = (state == RESP);
    assign resp_rdata    = resp_valid ? rdata_q : '0;
    assign resp_misalign = resp_valid && mis_q;
    assign resp_fault    = resp_valid && fault_q;
    assign mem_addr      = {3'b000, addr_q[63:3]};
    assign mem_wdata     = wbuf_q;
    assign mem_wr        = (state == WRITE);
endmodule

// File: tb/tb_load_store_unit.sv
// Scoreboard bench for load_store_unit: byte-array reference model, bench-side memory,
// directed cases followed by random traffic.
module tb_load_store_unit;
    localparam int DEPTH = 1024;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_valid = 1'b0, req_ready, req_store = 1'b0;
    logic [2:0]  req_funct3 = '0;
    logic [63:0] req_addr = '0, req_wdata = '0;
    logic        resp_valid, resp_misalign, resp_fault;
    logic [63:0] resp_rdata, mem_addr, mem_wdata, mem_rdata;
    logic        mem_wr;

    load_store_unit #(.DEPTH(DEPTH)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_store(req_store),
        .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
        .resp_valid(resp_valid), .resp_rdata(resp_rdata),
        .resp_misalign(resp_misalign), .resp_fault(resp_fault),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wr(mem_wr), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    // Bench-side data memory: combinational read, posedge write.
    logic [63:0] mem [DEPTH];
    always @(posedge clk) if (mem_wr) mem[int'(mem_addr % 64'(DEPTH))] <= mem_wdata;
    assign mem_rdata = mem[int'(mem_addr % 64'(DEPTH))];

    // Reference model: flat little-endian byte store.
    logic [7:0] refm [DEPTH*8];

    typedef struct {
        logic [63:0] rdata;
        logic        mis;
        logic        fault;
        int          lat;
        int          writes;
        int          acc;
    } exp_t;

    exp_t q[$];
    exp_t mon_e;
    int   errors = 0, checks = 0, cyc = 0, wr_cnt = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [63:0] ref_entry(input int idx);
        logic [63:0] v = '0;
        for (int i = 0; i < 8; i++) v[8*i +: 8] = refm[idx*8 + i];
        return v;
    endfunction

    function automatic exp_t model(input logic st, input logic [2:0] f3,
                                   input logic [63:0] a, input logic [63:0] wd);
        exp_t e;
        int   sz = 1 << f3[1:0];
        logic [63:0] v = '0;
        e.fault  = (a >= 64'(DEPTH * 8)) || (f3 == 3'b111) || (st && f3[2]);
        e.mis    = !e.fault && ((a % 64'(sz)) != 0);
        e.rdata  = '0;
        e.writes = 0;
        e.acc    = 0;
        if (e.fault || e.mis) begin
            e.lat = 1;
        end else if (st) begin
            for (int i = 0; i < sz; i++) refm[int'(a) + i] = wd[8*i +: 8];
            e.lat    = (sz == 8) ? 2 : 3;
            e.writes = 1;
        end else begin
            for (int i = 0; i < sz; i++) v[8*i +: 8] = refm[int'(a) + i];
            if (!f3[2] && sz < 8 && v[8*sz-1]) v = v | ~((64'd1 << (8*sz)) - 64'd1);
            e.rdata = v;
            e.lat   = 2;
        end
        return e;
    endfunction

    // Issue one request; when abort is set the request is not modelled or scoreboarded.
    task automatic issue(input logic st, input logic [2:0] f3, input logic [63:0] a,
                         input logic [63:0] wd, input logic abort);
        int   n = 0;
        exp_t e;
        @(negedge clk);
        while (!req_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!req_ready) begin
            checks++;
            errors++;
            $display("FAIL req_ready_timeout: got 0 expected 1");
            return;
        end
        req_valid  = 1'b1;
        req_store  = st;
        req_funct3 = f3;
        req_addr   = a;
        req_wdata  = wd;
        if (!abort) begin
            e     = model(st, f3, a, wd);
            e.acc = cyc;
            q.push_back(e);
        end
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        req_addr  = {$urandom, $urandom};
        req_wdata = {$urandom, $urandom};
    endtask

    task automatic drain();
        int n = 0;
        while (q.size() != 0 && n < 50) begin
            @(negedge clk);
            n++;
        end
        @(negedge clk);
        chk("drain_pending", 64'(q.size()), 64'd0);
    endtask

    // Monitor: pops the scoreboard on every response strobe.
    always @(negedge clk) begin
        if (rst_n) begin
            if (mem_wr) wr_cnt++;
            if (resp_valid) begin
                if (q.size() == 0) begin
                    chk("unexpected_resp", 64'd1, 64'd0);
                end else begin
                    mon_e = q.pop_front();
                    chk("resp_rdata",    resp_rdata,            mon_e.rdata);
                    chk("resp_misalign", 64'(resp_misalign),    64'(mon_e.mis));
                    chk("resp_fault",    64'(resp_fault),       64'(mon_e.fault));
                    chk("latency",       64'(cyc - mon_e.acc),  64'(mon_e.lat));
                    chk("mem_wr_cycles", 64'(wr_cnt),           64'(mon_e.writes));
                end
                wr_cnt = 0;
            end else begin
                chk("idle_resp_zero", {resp_rdata[63:2], resp_misalign, resp_fault}, 64'd0);
            end
        end
    end

    logic [63:0] saved, a;
    logic [2:0]  f3;
    logic        st;
    int          n;

    initial begin
        for (int i = 0; i < DEPTH; i++) begin
            mem[i] = {$urandom, $urandom};
            for (int b = 0; b < 8; b++) refm[i*8 + b] = mem[i][8*b +: 8];
        end
        #1;
        chk("rst_req_ready",  64'(req_ready),     64'd0);
        chk("rst_resp_valid", 64'(resp_valid),    64'd0);
        chk("rst_resp_rdata", resp_rdata,         64'd0);
        chk("rst_flags",      {62'd0, resp_misalign, resp_fault}, 64'd0);
        chk("rst_mem_wr",     64'(mem_wr),        64'd0);
        chk("rst_mem_addr",   mem_addr,           64'd0);
        chk("rst_mem_wdata",  mem_wdata,          64'd0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("post_rst_ready", 64'(req_ready), 64'd1);

        // SD then LD at 0x10
        issue(1'b1, 3'b011, 64'h10, 64'h1122334455667788, 1'b0);
        issue(1'b0, 3'b011, 64'h10, 64'h0, 1'b0);
        drain();
        chk("entry2_sd", mem[2], 64'h1122334455667788);
        // SB 0x13 read-modify-write
        issue(1'b1, 3'b000, 64'h13, 64'hAB, 1'b0);
        drain();
        chk("entry2_sb", mem[2], 64'h11223344AB667788);
        // Lane loads from entry 2
        issue(1'b0, 3'b000, 64'h13, 64'h0, 1'b0);
        issue(1'b0, 3'b100, 64'h13, 64'h0, 1'b0);
        issue(1'b0, 3'b001, 64'h12, 64'h0, 1'b0);
        issue(1'b0, 3'b110, 64'h14, 64'h0, 1'b0);
        // Misaligned
        saved = mem[1];
        issue(1'b0, 3'b010, 64'h12, 64'h0, 1'b0);
        issue(1'b1, 3'b011, 64'h0C, 64'hDEADBEEFCAFEF00D, 1'b0);
        drain();
        chk("entry1_unchanged", mem[1], saved);
        // Faults, including fault taking priority over misalign
        issue(1'b0, 3'b011, 64'h2000, 64'h0, 1'b0);
        issue(1'b0, 3'b111, 64'h8, 64'h0, 1'b0);
        issue(1'b1, 3'b100, 64'h8, 64'h55, 1'b0);
        issue(1'b0, 3'b001, 64'h2001, 64'h0, 1'b0);
        drain();

        // Reset during the WRITE of an SH: write must not land, no response
        saved = mem[4];
        issue(1'b1, 3'b001, 64'h20, 64'hBEEF, 1'b1);
        n = 0;
        while (!mem_wr && n < 10) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("abort_reached_write", 64'(mem_wr), 64'd1);
        rst_n = 1'b0;
        #1;
        chk("abort_mem_wr_drop", 64'(mem_wr),     64'd0);
        chk("abort_no_resp",     64'(resp_valid), 64'd0);
        chk("abort_ready_low",   64'(req_ready),  64'd0);
        repeat (2) @(negedge clk);
        chk("abort_entry4", mem[4], saved);
        rst_n = 1'b1;
        #1;
        chk("abort_ready_back", 64'(req_ready), 64'd1);
        issue(1'b0, 3'b011, 64'h20, 64'h0, 1'b0);
        drain();

        // Random traffic over entries 0..15 plus out-of-range addresses
        for (int k = 0; k < 300; k++) begin
            st = 1'($urandom_range(0, 1));
            f3 = 3'($urandom_range(0, 7));
            case ($urandom_range(0, 15))
                0:       a = 64'h2000 + 64'($urandom_range(0, 31));
                1:       a = {$urandom, $urandom};
                default: a = 64'($urandom_range(0, 127));
            endcase
            issue(st, f3, a, {$urandom, $urandom}, 1'b0);
        end
        drain();
        for (int i = 0; i < 16; i++) chk("final_entry", mem[i], ref_entry(i));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
